// File: rtl/lzx_univ_shift_reg.sv
// Universal shift register with a counted burst mode (IDLE -> RUN -> DONE).
// Optional even-parity output PAR when LZX_USR_PARITY_EN is defined.
module lzx_univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             CE,
  input  logic [2:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  input  logic [CNT_W-1:0] CNT,
  input  logic             START,
  output logic [WIDTH-1:0] Q,
  output logic             QSR,
  output logic             QSL,
  output logic             BUSY,
  output logic             DONE
`ifdef LZX_USR_PARITY_EN
  ,
  output logic             PAR
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mode_q;

  function automatic logic is_burst_mode(input logic [2:0] mode);
    return (mode == 3'b001) || (mode == 3'b010) || (mode == 3'b100) ||
           (mode == 3'b101) || (mode == 3'b110);
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       mode,
                                                input logic [WIDTH-1:0] q,
                                                input logic             dsr,
                                                input logic             dsl,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = q;
    unique case (mode)
      3'b001:  r = {dsr, q[WIDTH-1:1]};
      3'b010:  r = {q[WIDTH-2:0], dsl};
      3'b011:  r = d;
      3'b100:  r = {q[0], q[WIDTH-1:1]};
      3'b101:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b110:  r = {q[WIDTH-1], q[WIDTH-1:1]};
      default: r = q;
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (MR) begin
      q_q     <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (CE) begin
            if (START && is_burst_mode(S)) begin
              // Latch edge only; Q is untouched until the first RUN edge.
              mode_q  <= S;
              cnt_q   <= CNT;
              state_q <= (CNT != '0) ? StRun : StDone;
            end else begin
              q_q <= apply_op(S, q_q, DSR, DSL, D);
            end
          end
        end
        StRun: begin
          if (CE) begin
            q_q   <= apply_op(mode_q, q_q, DSR, DSL, D);
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Q    = q_q;
  assign QSR  = q_q[0];
  assign QSL  = q_q[WIDTH-1];
  assign BUSY = (state_q == StRun);
  assign DONE = (state_q == StDone);

`ifdef LZX_USR_PARITY_EN
  assign PAR = ^q_q;
`endif

endmodule

// File: tb/tb_lzx_univ_shift_reg.sv
// Self-checking bench for lzx_univ_shift_reg: vector table, directed burst
// sequences, then random stimulus against a queue-based reference model.
module tb_lzx_univ_shift_reg;

  logic       CLK;
  logic       MR;
  logic       CE;
  logic [2:0] S;
  logic       DSR;
  logic       DSL;
  logic [7:0] D;
  logic [3:0] CNT;
  logic       START;
  logic [7:0] Q;
  logic       QSR;
  logic       QSL;
  logic       BUSY;
  logic       DONE;
`ifdef LZX_USR_PARITY_EN
  logic       PAR;
`endif

  lzx_univ_shift_reg #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .CLK  (CLK),
    .MR   (MR),
    .CE   (CE),
    .S    (S),
    .DSR  (DSR),
    .DSL  (DSL),
    .D    (D),
    .CNT  (CNT),
    .START(START),
    .Q    (Q),
    .QSR  (QSR),
    .QSL  (QSL),
    .BUSY (BUSY),
    .DONE (DONE)
`ifdef LZX_USR_PARITY_EN
    ,
    .PAR  (PAR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input int q, input int busy, input int done);
    chk({tag, ".q"}, int'(Q), q);
    chk({tag, ".busy"}, int'(BUSY), busy);
    chk({tag, ".done"}, int'(DONE), done);
  endtask

  // Reference model: burst = queue of pending shift modes; done = one-cycle flag.
  int m_q;
  int pend[$];
  bit m_done;

  function automatic int op(int s, int q, int dsr, int dsl, int d);
    case (s)
      1:       return (q >> 1) | (dsr << 7);
      2:       return ((q << 1) | dsl) & 255;
      3:       return d;
      4:       return (q >> 1) | ((q & 1) << 7);
      5:       return ((q << 1) | (q >> 7)) & 255;
      6:       return (q >> 1) | (q & 128);
      default: return q;
    endcase
  endfunction

  function automatic bit is_burst(int s);
    return s == 1 || s == 2 || s == 4 || s == 5 || s == 6;
  endfunction

  task automatic model_step();
    if (MR) begin
      m_q = 0;
      pend.delete();
      m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (pend.size() > 0) begin
      if (CE) begin
        m_q = op(pend.pop_front(), m_q, int'(DSR), int'(DSL), int'(D));
        if (pend.size() == 0) m_done = 1;
      end
    end else if (CE) begin
      if (START && is_burst(int'(S))) begin
        for (int i = 0; i < int'(CNT); i++) pend.push_back(int'(S));
        if (CNT == 0) m_done = 1;
      end else begin
        m_q = op(int'(S), m_q, int'(DSR), int'(DSL), int'(D));
      end
    end
  endtask

  typedef struct {
    logic       ce;
    logic [2:0] s;
    logic [7:0] d;
    logic       dsr;
    logic       dsl;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{1'b1, 3'd1, 8'h00, 1'b1, 1'b0, 8'hD2};
    vecs[2]  = '{1'b0, 3'd3, 8'hFF, 1'b0, 1'b0, 8'hD2};
    vecs[3]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 1'b1, 8'hD2};
    vecs[4]  = '{1'b1, 3'd7, 8'hFF, 1'b1, 1'b1, 8'hD2};
    vecs[5]  = '{1'b1, 3'd3, 8'h80, 1'b0, 1'b0, 8'h80};
    vecs[6]  = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[7]  = '{1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 8'h60};
    vecs[8]  = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[9]  = '{1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 8'h81};
    vecs[10] = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h03};
    vecs[11] = '{1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h81};
    vecs[12] = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[13] = '{1'b1, 3'd3, 8'h07, 1'b0, 1'b0, 8'h07};
    vecs[14] = '{1'b1, 3'd3, 8'h03, 1'b0, 1'b0, 8'h03};
    vecs[15] = '{1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 8'h01};

    MR = 1'b1; CE = 1'b1; S = 3'd0; DSR = 1'b0; DSL = 1'b0;
    D = 8'h5A; CNT = 4'd0; START = 1'b0;
    tick();
    tick();
    chk_out("reset", 'h00, 0, 0);
    chk("reset.qsr", int'(QSR), 0);
    chk("reset.qsl", int'(QSL), 0);
    MR = 1'b0;

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      CE = v.ce; S = v.s; D = v.d; DSR = v.dsr; DSL = v.dsl; START = 1'b0;
      tick();
      chk($sformatf("vec%0d.q", i), int'(Q), int'(v.exp_q));
      chk($sformatf("vec%0d.qsr", i), int'(QSR), int'(v.exp_q[0]));
      chk($sformatf("vec%0d.qsl", i), int'(QSL), int'(v.exp_q[7]));
`ifdef LZX_USR_PARITY_EN
      chk($sformatf("vec%0d.par", i), int'(PAR), int'(^v.exp_q));
`endif
    end
    CE = 1'b1;

    // Rotate-left burst of 3 from 0x81.
    S = 3'd3; D = 8'h81; tick();
    S = 3'd5; CNT = 4'd3; START = 1'b1; tick();
    chk_out("rolk", 'h81, 1, 0);
    START = 1'b0; S = 3'd3; D = 8'hFF; CNT = 4'd9;
    tick(); chk_out("rol1", 'h03, 1, 0);
    tick(); chk_out("rol2", 'h06, 1, 0);
    tick(); chk_out("rol3", 'h0C, 0, 1);
    S = 3'd0;
    tick(); chk_out("rolend", 'h0C, 0, 0);

    // Zero-count burst; DONE returns to IDLE even with CE low.
    S = 3'd5; CNT = 4'd0; START = 1'b1; tick();
    chk_out("zc0", 'h0C, 0, 1);
    START = 1'b0; S = 3'd0; CE = 1'b0; tick();
    chk_out("zc1", 'h0C, 0, 0);
    CE = 1'b1;

    // START with a non-burst mode is a plain load.
    S = 3'd3; D = 8'h3C; CNT = 4'd5; START = 1'b1; tick();
    chk_out("startld", 'h3C, 0, 0);
    START = 1'b0;

    // CE stall mid-burst.
    S = 3'd3; D = 8'h01; tick();
    S = 3'd2; DSL = 1'b0; CNT = 4'd4; START = 1'b1; tick();
    chk_out("stl0", 'h01, 1, 0);
    START = 1'b0;
    tick(); chk_out("stl1", 'h02, 1, 0);
    CE = 1'b0;
    tick(); chk_out("stl2", 'h02, 1, 0);
    tick(); chk_out("stl3", 'h02, 1, 0);
    CE = 1'b1;
    tick(); chk_out("stl4", 'h04, 1, 0);
    tick(); chk_out("stl5", 'h08, 1, 0);
    tick(); chk_out("stl6", 'h10, 0, 1);
    tick(); chk_out("stl7", 'h10, 0, 0);

    // Reset mid-burst, then a fresh burst right after.
    S = 3'd3; D = 8'hF0; tick();
    S = 3'd1; DSR = 1'b0; CNT = 4'd5; START = 1'b1; tick();
    chk_out("mr0", 'hF0, 1, 0);
    START = 1'b0;
    tick(); chk_out("mr1", 'h78, 1, 0);
    MR = 1'b1; tick();
    chk_out("mr2", 'h00, 0, 0);
    MR = 1'b0; S = 3'd2; DSL = 1'b1; CNT = 4'd2; START = 1'b1; tick();
    chk_out("mr3", 'h00, 1, 0);
    START = 1'b0;
    tick(); chk_out("mr4", 'h01, 1, 0);
    tick(); chk_out("mr5", 'h03, 0, 1);
    tick(); chk_out("mr6", 'h03, 0, 0);

    // Random phase: synchronise the model with a reset first.
    MR = 1'b1; model_step(); tick(); MR = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      MR    = ($urandom_range(0, 63) == 0);
      CE    = ($urandom_range(0, 4) != 0);
      S     = 3'($urandom_range(0, 7));
      DSR   = 1'($urandom);
      DSL   = 1'($urandom);
      D     = 8'($urandom);
      CNT   = 4'($urandom_range(0, 5));
      START = ($urandom_range(0, 3) == 0);
      model_step();
      tick();
      chk("rnd.q", int'(Q), m_q);
      chk("rnd.qsr", int'(QSR), m_q & 1);
      chk("rnd.qsl", int'(QSL), (m_q >> 7) & 1);
      chk("rnd.busy", int'(BUSY), int'(pend.size() > 0));
      chk("rnd.done", int'(DONE), int'(m_done));
`ifdef LZX_USR_PARITY_EN
      chk("rnd.par", int'(PAR), int'(^(8'(m_q))));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
